// File: rtl/game_text_render.sv
// Text overlay stage: maps the pixel position onto a 16x8 character grid, fetches
// glyph rows through the external text/font ROMs and composites TXT_COLOR over rgb_in.
module game_text_render #(
    parameter int          X_POS     = 0,
    parameter int          Y_POS     = 0,
    parameter logic [11:0] TXT_COLOR = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [7:0]  char_xy,
    input  logic [6:0]  char_code,
    output logic [10:0] font_addr,
    input  logic [7:0]  char_pixels,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    logic [10:0] rel_x;
    logic [10:0] rel_y;
    logic        in_box;

    logic [7:0]  char_xy_d;
    logic [3:0]  line_d;
    logic [2:0]  bitsel_d;
    logic [10:0] font_addr_d;
    logic [11:0] rgb_out_d;

    logic [7:0]        char_xy_q;
    logic [10:0]       font_addr_q;
    logic [11:0]       rgb_out_q;
    logic [1:0][3:0]   line_sr_q;
    logic [3:0][2:0]   bitsel_sr_q;
    logic [3:0]        in_box_sr_q;
    logic [3:0][11:0]  rgb_sr_q;
    logic [4:0][10:0]  hcount_sr_q;
    logic [4:0][10:0]  vcount_sr_q;
    logic [4:0]        hsync_sr_q;
    logic [4:0]        vsync_sr_q;
    logic [4:0]        hblnk_sr_q;
    logic [4:0]        vblnk_sr_q;

    // Lower-bound compare keeps positions left/above the box from wrapping into it.
    assign rel_x  = hcount_in - 11'(X_POS);
    assign rel_y  = vcount_in - 11'(Y_POS);
    assign in_box = (hcount_in >= 11'(X_POS)) && (rel_x < 11'd128) &&
                    (vcount_in >= 11'(Y_POS)) && (rel_y < 11'd128);

    always_comb begin
        char_xy_d   = 8'h00;
        line_d      = 4'h0;
        bitsel_d    = 3'd0;
        if (in_box) begin
            char_xy_d = {1'b0, rel_y[6:4], rel_x[6:3]};
            line_d    = rel_y[3:0];
            bitsel_d  = rel_x[2:0];
        end
        font_addr_d = {char_code, line_sr_q[1]};
        rgb_out_d   = rgb_sr_q[3];
        if (in_box_sr_q[3] && char_pixels[3'd7 - bitsel_sr_q[3]]) begin
            rgb_out_d = TXT_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            char_xy_q   <= '0;
            font_addr_q <= '0;
            rgb_out_q   <= '0;
            line_sr_q   <= '0;
            bitsel_sr_q <= '0;
            in_box_sr_q <= '0;
            rgb_sr_q    <= '0;
            hcount_sr_q <= '0;
            vcount_sr_q <= '0;
            hsync_sr_q  <= '0;
            vsync_sr_q  <= '0;
            hblnk_sr_q  <= '0;
            vblnk_sr_q  <= '0;
        end else begin
            char_xy_q   <= char_xy_d;
            font_addr_q <= font_addr_d;
            rgb_out_q   <= rgb_out_d;
            line_sr_q   <= {line_sr_q[0], line_d};
            bitsel_sr_q <= {bitsel_sr_q[2:0], bitsel_d};
            in_box_sr_q <= {in_box_sr_q[2:0], in_box};
            rgb_sr_q    <= {rgb_sr_q[2:0], rgb_in};
            hcount_sr_q <= {hcount_sr_q[3:0], hcount_in};
            vcount_sr_q <= {vcount_sr_q[3:0], vcount_in};
            hsync_sr_q  <= {hsync_sr_q[3:0], hsync_in};
            vsync_sr_q  <= {vsync_sr_q[3:0], vsync_in};
            hblnk_sr_q  <= {hblnk_sr_q[3:0], hblnk_in};
            vblnk_sr_q  <= {vblnk_sr_q[3:0], vblnk_in};
        end
    end

    assign char_xy    = char_xy_q;
    assign font_addr  = font_addr_q;
    assign rgb_out    = rgb_out_q;
    assign hcount_out = hcount_sr_q[4];
    assign vcount_out = vcount_sr_q[4];
    assign hsync_out  = hsync_sr_q[4];
    assign vsync_out  = vsync_sr_q[4];
    assign hblnk_out  = hblnk_sr_q[4];
    assign vblnk_out  = vblnk_sr_q[4];

endmodule

// File: tb/tb_game_text_render.sv
// Bench for game_text_render: directed vector table, timing-pulse latency checks and a
// cycle-by-cycle reference model with registered text/font ROM models.
module tb_game_text_render;

    localparam int          XP  = 100;
    localparam int          YP  = 50;
    localparam logic [11:0] TXT = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [7:0]  char_xy;
    logic [6:0]  char_code = '0;
    logic [10:0] font_addr;
    logic [7:0]  char_pixels = '0;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    logic        force_en  = 1'b0;
    logic [7:0]  force_pix = '0;

    game_text_render #(.X_POS(XP), .Y_POS(YP), .TXT_COLOR(TXT)) dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .char_xy(char_xy), .char_code(char_code),
        .font_addr(font_addr), .char_pixels(char_pixels),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] txt_rom(input logic [7:0] a);
        return a[6:0] + 7'h21;
    endfunction

    function automatic logic [7:0] font_rom(input logic [10:0] a);
        return a[7:0] ^ {1'b0, a[10:4]} ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        char_code   <= txt_rom(char_xy);
        char_pixels <= force_en ? force_pix : font_rom(font_addr);
    end

    typedef struct {
        logic [10:0] h, v;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
    } rec_t;

    typedef struct {
        logic [10:0] h, v;
        logic [11:0] rgb;
        logic [7:0]  pix;
        logic [7:0]  xy;
        logic        fa_chk;
        logic [10:0] fa;
        logic [11:0] out;
    } vec_t;

    rec_t hist [4096];
    vec_t vt [9];
    int   cyc = 0;
    int   first_valid = 0;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic void ref_fields(input rec_t r, output logic ib, output logic [7:0] xy,
                                       output logic [3:0] line, output logic [2:0] bs);
        int rx, ry;
        rx   = int'(r.h) - XP;
        ry   = int'(r.v) - YP;
        ib   = (rx >= 0) && (rx < 128) && (ry >= 0) && (ry < 128);
        xy   = ib ? {1'b0, ry[6:4], rx[6:3]} : 8'h00;
        line = ry[3:0];
        bs   = rx[2:0];
    endfunction

    task automatic step(input bit chk);
        rec_t        r;
        logic        ib;
        logic [7:0]  xy, px;
        logic [3:0]  line;
        logic [2:0]  bs;
        logic [10:0] fa;
        logic [11:0] er;
        hist[cyc] = '{hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
        @(posedge clk);
        #1;
        if (!rst) begin
            first_valid = cyc + 1;
            if (chk) begin
                check("rst_char_xy", 32'(char_xy), 32'd0);
                check("rst_font_addr", 32'(font_addr), 32'd0);
                check("rst_rgb_out", 32'(rgb_out), 32'd0);
                check("rst_timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
            end
        end else if (chk) begin
            ref_fields(hist[cyc], ib, xy, line, bs);
            check("char_xy", 32'(char_xy), 32'(xy));
            if (cyc - 2 >= first_valid) begin
                ref_fields(hist[cyc-2], ib, xy, line, bs);
                if (ib) check("font_addr", 32'(font_addr), 32'({txt_rom(xy), line}));
            end
            if (cyc - 4 >= first_valid) begin
                r = hist[cyc-4];
                ref_fields(r, ib, xy, line, bs);
                fa = {txt_rom(xy), line};
                px = font_rom(fa);
                er = (ib && px[3'd7 - bs]) ? TXT : r.rgb;
                check("rgb_out", 32'(rgb_out), 32'(er));
                check("hv_out", 32'({hcount_out, vcount_out}), 32'({r.h, r.v}));
                check("sync_blnk_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
                      32'({r.hs, r.vs, r.hb, r.vb}));
            end else begin
                check("refill_rgb_out", 32'(rgb_out), 32'd0);
                check("refill_timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
            end
        end
        cyc++;
    endtask

    task automatic drive_rand();
        if ($urandom_range(7) == 0) begin
            hcount_in = 11'($urandom_range(2047));
            vcount_in = 11'($urandom_range(2047));
        end else begin
            hcount_in = 11'($urandom_range(XP + 132, XP - 4));
            vcount_in = 11'($urandom_range(YP + 132, YP - 4));
        end
        {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'($urandom);
        rgb_in = 12'($urandom);
    endtask

    initial begin
        vt[0] = '{11'd100, 11'd50,  12'h123, 8'h80, 8'h00, 1'b1, 11'h210, TXT};
        vt[1] = '{11'd135, 11'd151, 12'h456, 8'h08, 8'h64, 1'b1, 11'h055, 12'h456};
        vt[2] = '{11'd135, 11'd151, 12'h456, 8'h10, 8'h64, 1'b1, 11'h055, TXT};
        vt[3] = '{11'd228, 11'd60,  12'h0A5, 8'hFF, 8'h00, 1'b0, 11'h000, 12'h0A5};
        vt[4] = '{11'd227, 11'd177, 12'h3C3, 8'h01, 8'h7F, 1'b1, 11'h20F, TXT};
        vt[5] = '{11'd99,  11'd60,  12'h777, 8'hFF, 8'h00, 1'b0, 11'h000, 12'h777};
        vt[6] = '{11'd150, 11'd49,  12'h321, 8'hFF, 8'h00, 1'b0, 11'h000, 12'h321};
        vt[7] = '{11'd150, 11'd178, 12'h654, 8'hFF, 8'h00, 1'b0, 11'h000, 12'h654};
        vt[8] = '{11'd100, 11'd100, 12'hABC, 8'h7F, 8'h30, 1'b1, 11'h512, 12'hABC};

        // reset held with live inputs, then free-running stream
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin drive_rand(); step(1'b1); end
        rst = 1'b1;
        for (int i = 0; i < 200; i++) begin drive_rand(); step(1'b1); end

        // directed vectors, held steady with a forced font row
        force_en = 1'b1;
        {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'b0;
        for (int i = 0; i < 9; i++) begin
            hcount_in = vt[i].h; vcount_in = vt[i].v; rgb_in = vt[i].rgb; force_pix = vt[i].pix;
            for (int k = 0; k < 6; k++) step(1'b0);
            check($sformatf("vec%0d_char_xy", i), 32'(char_xy), 32'(vt[i].xy));
            if (vt[i].fa_chk) check($sformatf("vec%0d_font_addr", i), 32'(font_addr), 32'(vt[i].fa));
            check($sformatf("vec%0d_rgb_out", i), 32'(rgb_out), 32'(vt[i].out));
        end
        force_en = 1'b0;
        for (int i = 0; i < 6; i++) begin drive_rand(); step(1'b0); end

        // single-cycle pulse on each sync/blank input must emerge exactly 5 clk later
        for (int s = 0; s < 4; s++) begin
            logic [10:0] seen;
            logic        o;
            seen = '0;
            hcount_in = 11'd1000; vcount_in = 11'd1000; rgb_in = 12'h111;
            {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'b0;
            for (int k = 0; k < 6; k++) step(1'b1);
            {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'(4'b1000 >> s);
            for (int k = 1; k <= 10; k++) begin
                step(1'b1);
                {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'b0;
                case (s)
                    0:       o = hsync_out;
                    1:       o = vsync_out;
                    2:       o = hblnk_out;
                    default: o = vblnk_out;
                endcase
                seen[k] = o;
            end
            check($sformatf("pulse%0d_latency", s), 32'(seen), 32'(11'b00000100000));
        end

        // mid-line resets of one and two clocks
        for (int i = 0; i < 20; i++) begin drive_rand(); step(1'b1); end
        rst = 1'b0; drive_rand(); step(1'b1);
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin drive_rand(); step(1'b1); end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin drive_rand(); step(1'b1); end
        rst = 1'b1;

        // sweep across both horizontal box edges on an in-box line
        for (int x = XP - 3; x <= XP + 131; x++) begin
            hcount_in = 11'(x); vcount_in = 11'(YP + 7);
            rgb_in = 12'($urandom);
            {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'($urandom);
            step(1'b1);
        end
        for (int i = 0; i < 200; i++) begin drive_rand(); step(1'b1); end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
